fifo_prog: RTL
==============

# fifo_prog

Parametrised synchronous FIFO: the next generation of the team's fixed-size FIFO. Adds configurable width and depth, run-time almost-empty/almost-full thresholds, an occupancy count, a read-data valid strobe and sticky overflow/underflow error flags. It sits between a data producer and a consumer in the same clock domain and replaces the fixed-size FIFO in new datapaths.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH words (default 8)

- clk  in  1  clock; all state changes on the rising edge
- Reset  in  1  reset, synchronous and active-high; takes priority over every other input
- Enable  in  1  global enable; when low, all state is frozen
- write_enable  in  1  write request
- read_enable  in  1  read request
- FIFO_data_in  in  DATA_WIDTH  write data
- umbral_ae  in  ADDR_WIDTH+1  almost-empty threshold
- umbral_af  in  ADDR_WIDTH+1  almost-full threshold
- FIFO_data_out  out  DATA_WIDTH  read data
- FIFO_data_valid  out  1  FIFO_data_out carries a freshly read word
- FIFO_count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
- FIFO_empty, FIFO_full  out  1  occupancy flags
- FIFO_almost_empty, FIFO_almost_full  out  1  threshold flags
- FIFO_overflow, FIFO_underflow  out  1  sticky error flags

## Operation
- Storage is a DEPTH x DATA_WIDTH register array with ADDR_WIDTH-bit write and read pointers. Pointers wrap naturally from DEPTH-1 to 0.
- A write is accepted when Enable & write_enable & !FIFO_full. The array is written at wr_ptr, and wr_ptr increments.
- A read is accepted when Enable & read_enable & !FIFO_empty. rd_ptr increments.
- Full and empty decisions always use the registered count from before the edge:
  - write while full: rejected, even if a read is accepted in the same cycle;
  - read while empty: rejected, even if a write is accepted in the same cycle.
- FIFO_count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Flags are combinational from FIFO_count and the threshold inputs:
  - FIFO_empty = (count == 0);
  - FIFO_full = (count == DEPTH);
  - FIFO_almost_empty = (count <= umbral_ae);
  - FIFO_almost_full = (count >= umbral_af).
- Thresholds are live inputs, not latched. Values greater than DEPTH are legal and simply saturate the flag's meaning.
- FIFO_overflow is set on Enable & write_enable & FIFO_full. FIFO_underflow is set on Enable & read_enable & FIFO_empty. Both stay set until Reset.
- Enable low: no pointer, count, memory, output or error change. FIFO_data_valid is forced to 0 on the next edge.
- Reset: pointers, count, FIFO_data_out, FIFO_data_valid and both error flags go to 0. Memory contents are not cleared. Resulting flags: FIFO_empty=1, FIFO_full=0, FIFO_almost_empty=1, FIFO_almost_full=(umbral_af==0).
- Reset mid-operation discards all stored words. The next accepted write lands at address 0.

## Timing
- Write-to-visibility: a word written at edge N counts in FIFO_count and the flags after edge N. It is readable starting at cycle N+1.
- Read latency (default mode): a read accepted at edge N drives FIFO_data_out and FIFO_data_valid=1 after edge N. Valid lasts one cycle per accepted read.
- Without an accepted read, FIFO_data_out holds its last value and FIFO_data_valid=0.
- Back-to-back reads produce one word per cycle, with valid held high continuously.
- Simultaneous accepted read and write at any occupancy 0<count<DEPTH: count unchanged, throughput one word in and one word out per cycle.

## Configuration
- FIFO_FWFT_EN defined (first-word-fall-through mode):
  - FIFO_data_out = mem[rd_ptr], combinational, whenever !FIFO_empty;
  - FIFO_data_valid = !FIFO_empty;
  - an accepted read pops the word and presents the next one in the same cycle as the pointer update;
  - when empty, FIFO_data_out is 0.
- FIFO_FWFT_EN undefined: registered-read behaviour as described in Timing.
- Flag, count and error behaviour are identical in both modes.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=3, umbral_ae=2, umbral_af=6.

- Reset, then idle: count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_out=0, valid=0, overflow=0, underflow=0.
- Write 0x01..0x08 on 8 consecutive cycles: almost_empty drops after the 3rd write, almost_full rises after the 6th, full=1 and count=8 after the 8th. A 9th write sets overflow=1, count stays 8.
- From full, read 8 consecutive cycles: data_out = 0x01..0x08 one cycle after each read, valid high for 8 cycles. Then empty=1. A further read sets underflow=1.
- At count=4, assert read and write together for 10 cycles: count stays 4, outputs follow FIFO order, pointers wrap past 7 with no data corruption.
- Write 3 words, drop Enable for 5 cycles with read_enable=1: no change in count or data_out, valid=0. Then assert Reset: count=0 and the error flags are cleared.
- With FIFO_FWFT_EN defined, write 0xA5: data_out=0xA5 and valid=1 one cycle later with no read. Reading pops it and sets empty=1.

Source files
------------

// File: rtl/fifo_prog_if.sv
// fifo_prog_if: producer/consumer bundle for the fifo_prog synchronous FIFO.
// Handshake: a write is taken on a rising edge when Enable & write_enable &
// !FIFO_full; a read is taken when Enable & read_enable & !FIFO_empty. Requests
// made while full/empty are dropped and raise the sticky overflow/underflow
// flags. FIFO_data_valid marks the cycle(s) in which FIFO_data_out carries a
// freshly read word.
interface fifo_prog_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  Enable;
  logic                  write_enable;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] FIFO_data_in;
  logic [ADDR_WIDTH:0]   umbral_ae;
  logic [ADDR_WIDTH:0]   umbral_af;
  logic [DATA_WIDTH-1:0] FIFO_data_out;
  logic                  FIFO_data_valid;
  logic [ADDR_WIDTH:0]   FIFO_count;
  logic                  FIFO_empty;
  logic                  FIFO_full;
  logic                  FIFO_almost_empty;
  logic                  FIFO_almost_full;
  logic                  FIFO_overflow;
  logic                  FIFO_underflow;

  modport master (
    output Enable, write_enable, read_enable, FIFO_data_in, umbral_ae, umbral_af,
    input  FIFO_data_out, FIFO_data_valid, FIFO_count, FIFO_empty, FIFO_full,
           FIFO_almost_empty, FIFO_almost_full, FIFO_overflow, FIFO_underflow
  );

  modport slave (
    input  Enable, write_enable, read_enable, FIFO_data_in, umbral_ae, umbral_af,
    output FIFO_data_out, FIFO_data_valid, FIFO_count, FIFO_empty, FIFO_full,
           FIFO_almost_empty, FIFO_almost_full, FIFO_overflow, FIFO_underflow
  );
endinterface

// File: rtl/fifo_prog.sv
// fifo_prog: parametrised synchronous FIFO with live almost-empty/almost-full
// thresholds, occupancy count, read-data valid strobe and sticky error flags.
// Optional feature macro: FIFO_FWFT_EN selects first-word-fall-through output;
// when undefined, read data is registered and appears after the read edge.
module fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input logic        clk,
  input logic        Reset,
  fifo_prog_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  empty, full;
  logic                  wr_acc, rd_acc;

  // Occupancy flags always come from the count registered before the edge.
  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH_C);
  assign wr_acc = bus.Enable & bus.write_enable & ~full;
  assign rd_acc = bus.Enable & bus.read_enable & ~empty;

  // Next-state for pointers, count and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_acc && !rd_acc) count_d = count_q + CNT_ONE;
    if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;
    if (bus.Enable && bus.write_enable && full)  ovf_d = 1'b1;
    if (bus.Enable && bus.read_enable  && empty) unf_d = 1'b1;
  end

  // Control state: reset wins; Enable low freezes everything (wr_acc/rd_acc
  // are already gated by Enable, so the _d values equal the _q values).
  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!Reset && wr_acc) mem_q[wr_ptr_q] <= bus.FIFO_data_in;
  end

`ifdef FIFO_FWFT_EN
  // Head word is always presented; zero when nothing is stored.
  assign bus.FIFO_data_out   = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.FIFO_data_valid = ~empty;
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;

  // Registered read port: data holds between reads, valid pulses per read.
  always_comb begin
    data_out_d = data_out_q;
    valid_d    = rd_acc;
    if (rd_acc) data_out_d = mem_q[rd_ptr_q];
  end

  // Output registers; valid drops on any edge without an accepted read.
  always_ff @(posedge clk) begin
    if (Reset) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.FIFO_data_out   = data_out_q;
  assign bus.FIFO_data_valid = valid_q;
`endif

  assign bus.FIFO_count        = count_q;
  assign bus.FIFO_empty        = empty;
  assign bus.FIFO_full         = full;
  assign bus.FIFO_almost_empty = (count_q <= bus.umbral_ae);
  assign bus.FIFO_almost_full  = (count_q >= bus.umbral_af);
  assign bus.FIFO_overflow     = ovf_q;
  assign bus.FIFO_underflow    = unf_q;
endmodule
